// File: rtl/layer_header_regfile.sv
// Layer-header register file: 32 layers x 8 x 16-bit registers behind the GPU
// command bus, with a renderer read port and a bulk clear-all sweep.
module layer_header_regfile #(
  parameter int          NUM_LAYERS        = 32,
  parameter logic [15:0] CMD_CLEAR_HEADERS = 16'h0002
) (
  input  logic        gpuClock,
  input  logic        reset,
  input  logic [15:0] gpuCommand,
  input  logic [15:0] gpuData,
  output logic [15:0] dataFromGpu,
  output logic        headerBusy,
  output logic        cmdError,
  input  logic [4:0]  renderLayer,
  input  logic [2:0]  renderReg,
  output logic [15:0] renderData
);

  localparam int          DEPTH     = NUM_LAYERS * 8;
  localparam logic [6:0]  OP_READ   = 7'b0100100;
  localparam logic [6:0]  OP_WRITE  = 7'b1000100;
  localparam logic [15:0] CMD_NOP   = 16'h0000;
  localparam logic [15:0] CMD_FRAME = 16'h0001;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t      r_state;
  logic [7:0]  r_addr;
  logic [15:0] r_prev_cmd;
  logic [15:0] r_data_out;
  logic [15:0] r_render_data;
  logic        r_busy;
  logic        r_error;
  logic [15:0] r_mem [0:DEPTH-1];

  logic [6:0]  w_opcode;
  logic [7:0]  w_host_addr;
  logic [7:0]  w_render_addr;
  logic        w_is_read;
  logic        w_is_write;
  logic        w_is_clear;
  logic        w_is_benign;
  logic        w_malformed;
  logic        w_clear_go;
  logic        w_mem_we;
  logic [7:0]  w_mem_addr;
  logic [15:0] w_mem_wdata;

  // Command field decode and classification.
  always_comb begin
    w_opcode      = gpuCommand[15:9];
    w_host_addr   = {gpuCommand[4:0], gpuCommand[8:6]};
    w_render_addr = {renderLayer, renderReg};
    w_is_read     = (w_opcode == OP_READ)  && (gpuCommand[5] == 1'b0);
    w_is_write    = (w_opcode == OP_WRITE) && (gpuCommand[5] == 1'b0);
    w_is_clear    = (gpuCommand == CMD_CLEAR_HEADERS);
    w_is_benign   = (gpuCommand == CMD_NOP) || (gpuCommand == CMD_FRAME);
    w_malformed   = !(w_is_read || w_is_write || w_is_clear || w_is_benign);
    // A held clear word only fires on its first cycle.
    w_clear_go    = (r_state == ST_IDLE) && w_is_clear && (r_prev_cmd != CMD_CLEAR_HEADERS);
  end

  // Storage write port: the sweep owns it in CLEAR, host writes own it in IDLE.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = w_host_addr;
    w_mem_wdata = gpuData;
    if (r_state == ST_CLEAR) begin
      w_mem_we    = reset;
      w_mem_addr  = r_addr;
      w_mem_wdata = 16'h0000;
    end else begin
      w_mem_we    = reset && w_is_write && !w_clear_go;
      w_mem_addr  = w_host_addr;
      w_mem_wdata = gpuData;
    end
  end

  // Header storage; deliberately not reset, only the clear sweep zeroes it.
  always_ff @(posedge gpuClock) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // Control FSM with registered host/render read data and status flags.
  always_ff @(posedge gpuClock) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_addr        <= 8'h00;
      r_prev_cmd    <= 16'h0000;
      r_data_out    <= 16'h0000;
      r_render_data <= 16'h0000;
      r_busy        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_prev_cmd <= gpuCommand;
      if (r_state == ST_CLEAR) begin
        r_render_data <= 16'h0000;
      end else begin
        r_render_data <= r_mem[w_render_addr];
      end
      case (r_state)
        ST_IDLE: begin
          if (w_clear_go) begin
            r_state <= ST_CLEAR;
            r_addr  <= 8'h00;
            r_busy  <= 1'b1;
          end else if (w_is_read) begin
            r_data_out <= r_mem[w_host_addr];
          end else if (w_malformed) begin
            r_error <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          if (r_addr == 8'hFF) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_addr <= r_addr + 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dataFromGpu = r_data_out;
  assign headerBusy  = r_busy;
  assign cmdError    = r_error;
  assign renderData  = r_render_data;

endmodule
